// File: rtl/sync_fifo.sv
// sync_fifo: single-clock DEPTH x DATA_W FIFO, normal (non-show-ahead) read mode,
// registered empty/full flags and a modulo-DEPTH occupancy count.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] pi_data,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic [DATA_W-1:0] po_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W-1:0] usedw
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   count_nxt;
  logic              wr_acc;
  logic              rd_acc;

  // Acceptance uses the pre-edge flags, so a full FIFO only reads and an empty one only writes.
  always_comb begin
    wr_acc = wr_req && !full;
    rd_acc = rd_req && !empty;
  end

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + (ADDR_W+1)'(1);
      2'b01:   count_nxt = count - (ADDR_W+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge sys_clk) begin
    if (wr_acc) begin
      mem[wptr] <= pi_data;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      po_data <= '0;
      empty   <= 1'b1;
      full    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wptr <= wptr + ADDR_W'(1);
      end
      if (rd_acc) begin
        po_data <= mem[rptr];
        rptr    <= rptr + ADDR_W'(1);
      end
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_FULL);
    end
  end

  always_comb begin
    usedw = count[ADDR_W-1:0];
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: the driver predicts read data into a queue,
// a negedge monitor pops and compares, and also checks flags and po_data hold.
module tb_sync_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [DATA_W-1:0] pi_data = '0;
  logic              wr_req = 1'b0;
  logic              rd_req = 1'b0;
  logic [DATA_W-1:0] po_data;
  logic              empty;
  logic              full;
  logic [ADDR_W-1:0] usedw;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .pi_data  (pi_data),
    .wr_req   (wr_req),
    .rd_req   (rd_req),
    .po_data  (po_data),
    .empty    (empty),
    .full     (full),
    .usedw    (usedw)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  logic [DATA_W-1:0] model_q [$];
  logic [DATA_W-1:0] exp_q   [$];
  int                m_cnt   = 0;
  logic [DATA_W-1:0] m_po    = '0;
  logic              rd_fire = 1'b0;
  logic              mon_en  = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // One clock of stimulus; the reference state is advanced at the same edge.
  task automatic cycle(input logic w, input logic r, input logic [DATA_W-1:0] d);
    logic wacc;
    logic racc;
    wr_req  = w;
    rd_req  = r;
    pi_data = d;
    @(posedge sys_clk);
    wacc = w && (m_cnt != DEPTH);
    racc = r && (m_cnt != 0);
    rd_fire = racc;
    if (racc) begin
      m_po = model_q.pop_front();
      exp_q.push_back(m_po);
    end
    if (wacc) model_q.push_back(d);
    if (wacc && !racc) m_cnt++;
    if (racc && !wacc) m_cnt--;
    #1;
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_q.delete();
    m_cnt   = 0;
    m_po    = '0;
    rd_fire = 1'b0;
  endtask

  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (rd_fire) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underrun", 1, 0);
        end else begin
          chk("rd_data", int'(po_data), int'(exp_q.pop_front()));
        end
      end
      chk("po_data_hold", int'(po_data), int'(m_po));
      chk("empty", int'(empty), int'(m_cnt == 0));
      chk("full",  int'(full),  int'(m_cnt == DEPTH));
      chk("usedw", int'(usedw), m_cnt % DEPTH);
    end
  end

  initial begin
    #12;
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full), 0);
    chk("rst_usedw", int'(usedw), 0);
    chk("rst_po",    int'(po_data), 0);
    sys_rst_n = 1'b1;
    mon_en    = 1'b1;
    @(posedge sys_clk); #1;
    repeat (3) cycle(1'b0, 1'b0, '0);

    // Slow fill 0..255, one write every 4 cycles.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b0, DATA_W'(i));
      if (i < DEPTH - 1) chk("fill_usedw", int'(usedw), i + 1);
      repeat (3) cycle(1'b0, 1'b0, '0);
    end
    chk("filled_full",  int'(full), 1);
    chk("filled_usedw", int'(usedw), 0);
    chk("filled_empty", int'(empty), 0);

    // Continuous drain: 0,1,...,255.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0);
      chk("drain_seq", int'(po_data), i);
    end
    chk("drained_empty", int'(empty), 1);
    chk("drained_usedw", int'(usedw), 0);

    // Back-to-back refill with 255-i, then a write while full must be dropped.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, DATA_W'(255 - i));
    chk("refill_full", int'(full), 1);
    cycle(1'b1, 1'b0, 8'hAA);
    chk("ovf_full",  int'(full), 1);
    chk("ovf_usedw", int'(usedw), 0);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 1'b1, '0);
      chk("ovf_drain_seq", int'(po_data), 255 - i);
    end
    chk("ovf_empty", int'(empty), 1);

    // Underflow: po_data must keep the last read value (0).
    cycle(1'b0, 1'b1, '0);
    cycle(1'b0, 1'b1, '0);
    chk("udf_po",    int'(po_data), 0);
    chk("udf_usedw", int'(usedw), 0);
    chk("udf_empty", int'(empty), 1);

    // Empty with simultaneous read+write: only the write happens.
    cycle(1'b1, 1'b1, 8'h5C);
    chk("empty_rw_usedw", int'(usedw), 1);
    chk("empty_rw_po",    int'(po_data), 0);
    cycle(1'b0, 1'b1, '0);
    chk("empty_rw_data",  int'(po_data), 8'h5C);

    // Ten stored, then 20 cycles of simultaneous read+write.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, DATA_W'(16 + i));
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, DATA_W'(100 + i));
      chk("simul_usedw", int'(usedw), 10);
      chk("simul_data",  int'(po_data), (i < 10) ? 16 + i : 100 + i - 10);
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, '0);
      chk("simul_tail", int'(po_data), 110 + i);
    end
    chk("simul_empty", int'(empty), 1);

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DATA_W'(200 + i));
    chk("pre_rst_usedw", int'(usedw), 5);
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_empty", int'(empty), 1);
    chk("async_rst_usedw", int'(usedw), 0);
    chk("async_rst_full",  int'(full), 0);
    chk("async_rst_po",    int'(po_data), 0);
    model_reset();
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk); #1;

    // Post-reset sanity: one write then one read.
    cycle(1'b1, 1'b0, 8'h3C);
    chk("post_rst_usedw", int'(usedw), 1);
    cycle(1'b0, 1'b1, '0);
    chk("post_rst_data",  int'(po_data), 8'h3C);
    repeat (2) cycle(1'b0, 1'b0, '0);

    chk("scoreboard_drained", exp_q.size(), 0);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
